// File: rtl/bus_reg_bank.sv
// Bank of bus-accessible registers with read-only and self-clearing slices.
// Latency: writes land and reads return one cycle after the CS cycle.
// Backpressure: none; a transaction is accepted every cycle CS is high.
module bus_reg_bank #(
  parameter int BUS_WIDTH  = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [NUM_REGS*BUS_WIDTH-1:0] INIT_VALS  = '0,
  parameter logic [NUM_REGS-1:0]           RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]           PULSE_MASK = '0
) (
  input  logic                          i_Bus_Clk,
  input  logic                          i_Bus_Rst_L,
  input  logic                          i_Bus_CS,
  input  logic                          i_Bus_Wr_Rd_n,
  input  logic [ADDR_WIDTH-1:0]         i_Bus_Addr,
  input  logic [BUS_WIDTH-1:0]          i_Bus_Wr_Data,
  output logic [BUS_WIDTH-1:0]          o_Bus_Rd_Data,
  output logic                          o_Bus_Rd_DV,
  output logic                          o_Bus_Err,
  input  logic [NUM_REGS*BUS_WIDTH-1:0] i_Regs,
  output logic [NUM_REGS*BUS_WIDTH-1:0] o_Regs,
  output logic [NUM_REGS-1:0]           o_Reg_Wr_Strobe
);

  logic                 wr_en;
  logic                 rd_en;
  logic [NUM_REGS-1:0]  hit;
  logic [NUM_REGS-1:0]  wr_sel;
  logic [BUS_WIDTH-1:0] rd_mux;
  logic                 in_range;
  logic                 ro_hit;
  logic                 bus_err;

  assign wr_en = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_en = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  // Full-width address decode: addresses at or above NUM_REGS match nothing.
  always_comb begin
    hit    = '0;
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_Bus_Addr == ADDR_WIDTH'(k)) begin
        hit[k] = 1'b1;
        rd_mux = i_Regs[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  assign in_range = |hit;
  assign ro_hit   = |(hit & RO_MASK);
  assign wr_sel   = hit & ~RO_MASK & {NUM_REGS{wr_en}};
  // Out-of-range read/write, or a write aimed at a read-only slice.
  assign bus_err  = i_Bus_CS & (~in_range | (wr_en & ro_hit));

  // Register slices: accepted write wins, otherwise pulse slices fall back to init.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      o_Regs <= INIT_VALS;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_sel[k]) begin
          o_Regs[k*BUS_WIDTH +: BUS_WIDTH] <= i_Bus_Wr_Data;
        end else if (PULSE_MASK[k]) begin
          o_Regs[k*BUS_WIDTH +: BUS_WIDTH] <= INIT_VALS[k*BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  // Bus response flops: pulses every cycle, read data holds between reads.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      o_Bus_Rd_Data   <= '0;
      o_Bus_Rd_DV     <= 1'b0;
      o_Bus_Err       <= 1'b0;
      o_Reg_Wr_Strobe <= '0;
    end else begin
      o_Bus_Rd_DV     <= rd_en;
      o_Bus_Err       <= bus_err;
      o_Reg_Wr_Strobe <= wr_sel;
      if (rd_en) begin
        o_Bus_Rd_Data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_bus_reg_bank.sv
module tb_bus_reg_bank;

  localparam logic [95:0] A_INIT  = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h1234};
  localparam logic [5:0]  A_RO    = 6'b000010;
  localparam logic [5:0]  A_PULSE = 6'b010000;
  localparam logic [15:0] FAB1    = 16'h5A5A;

  typedef struct packed {
    logic        dv;
    logic [15:0] rdata;
    logic        err;
    logic [5:0]  strb;
    logic [95:0] regs;
  } exp_a_t;

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } stim_t;

  int tests  = 0;
  int failed = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 6 registers on a 3-bit address, init/RO/pulse slices.
  logic        a_cs, a_wr, a_dv, a_err;
  logic [2:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [95:0] a_iregs, a_regs;
  logic [5:0]  a_strb;
  // Slice 1 is fabric status; the others loop back from the register outputs.
  assign a_iregs = {a_regs[95:32], FAB1, a_regs[15:0]};

  bus_reg_bank #(
    .BUS_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3),
    .INIT_VALS(A_INIT), .RO_MASK(A_RO), .PULSE_MASK(A_PULSE)
  ) dut_a (
    .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .i_Bus_CS(a_cs), .i_Bus_Wr_Rd_n(a_wr),
    .i_Bus_Addr(a_addr), .i_Bus_Wr_Data(a_wdata), .o_Bus_Rd_Data(a_rdata),
    .o_Bus_Rd_DV(a_dv), .o_Bus_Err(a_err), .i_Regs(a_iregs), .o_Regs(a_regs),
    .o_Reg_Wr_Strobe(a_strb)
  );

  // Instance B: 8 registers of 32 bits, full address space.
  logic         b_cs, b_wr, b_dv, b_err;
  logic [2:0]   b_addr;
  logic [31:0]  b_wdata, b_rdata;
  logic [255:0] b_regs;
  logic [7:0]   b_strb;

  bus_reg_bank #(
    .BUS_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(3)
  ) dut_b (
    .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .i_Bus_CS(b_cs), .i_Bus_Wr_Rd_n(b_wr),
    .i_Bus_Addr(b_addr), .i_Bus_Wr_Data(b_wdata), .o_Bus_Rd_Data(b_rdata),
    .o_Bus_Rd_DV(b_dv), .o_Bus_Err(b_err), .i_Regs(b_regs), .o_Regs(b_regs),
    .o_Reg_Wr_Strobe(b_strb)
  );

  // Reference state for instance A and its scoreboard.
  logic [15:0] m_regs [6];
  logic [15:0] m_rdata;
  exp_a_t      qa[$];
  logic [31:0] qb[$];

  function automatic stim_t mk(input logic cs, input logic wr, input logic [2:0] addr, input logic [15:0] data);
    stim_t s;
    s.cs = cs; s.wr = wr; s.addr = addr; s.data = data;
    return s;
  endfunction

  task automatic model_reset();
    logic [95:0] init_v;
    init_v = A_INIT;
    for (int k = 0; k < 6; k++) m_regs[k] = init_v[k*16 +: 16];
    m_rdata = 16'h0000;
    qa.delete();
  endtask

  // Drive one bus cycle on A, push the expected post-edge outputs, then advance.
  task automatic step_a(input stim_t s);
    exp_a_t      e;
    logic [15:0] nxt [6];
    logic [95:0] init_v;
    logic [5:0]  ro_v, pulse_v;
    init_v = A_INIT; ro_v = A_RO; pulse_v = A_PULSE;
    a_cs = s.cs; a_wr = s.wr; a_addr = s.addr; a_wdata = s.data;
    e.dv = 1'b0; e.err = 1'b0; e.strb = 6'b0; e.rdata = m_rdata;
    for (int k = 0; k < 6; k++) nxt[k] = pulse_v[k] ? init_v[k*16 +: 16] : m_regs[k];
    if (s.cs && !s.wr) begin
      e.dv = 1'b1;
      if (s.addr < 3'd6) e.rdata = (s.addr == 3'd1) ? FAB1 : m_regs[s.addr];
      else begin e.rdata = 16'h0000; e.err = 1'b1; end
      m_rdata = e.rdata;
    end
    if (s.cs && s.wr) begin
      if (s.addr >= 3'd6) e.err = 1'b1;
      else if (ro_v[s.addr]) e.err = 1'b1;
      else begin nxt[s.addr] = s.data; e.strb[s.addr] = 1'b1; end
    end
    for (int k = 0; k < 6; k++) begin
      m_regs[k] = nxt[k];
      e.regs[k*16 +: 16] = nxt[k];
    end
    qa.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_cs = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_cs = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    tests++;
    if ({a_dv, a_rdata, a_err, a_strb, a_regs} !== {1'b0, 16'h0, 1'b0, 6'h0, A_INIT} ||
        {b_dv, b_err, b_strb, b_rdata, b_regs} !== '0) begin
      failed++;
      $display("FAIL reset_values: got dv=%b rd=%h err=%b strb=%b regs=%h, expected 0/0/0/0 regs=%h",
               a_dv, a_rdata, a_err, a_strb, a_regs, A_INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Write in flight when reset hits must leave no trace.
    a_cs = 1; a_wr = 1; a_addr = 3'd2; a_wdata = 16'hFFFF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_cs = 0; a_wr = 0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({a_dv, a_err, a_strb, a_regs} !== {1'b0, 1'b0, 6'h0, A_INIT}) begin
      failed++;
      $display("FAIL reset_abort: got dv=%b err=%b strb=%b regs=%h, expected 0/0/0 regs=%h",
               a_dv, a_err, a_strb, a_regs, A_INIT);
    end
  endtask

  task automatic test_write_read();
    stim_t  st [6];
    exp_a_t e;
    st[0] = mk(1, 1, 3'd2, 16'hA5A5);
    st[1] = mk(1, 0, 3'd2, 16'h0000);
    st[2] = mk(1, 1, 3'd0, 16'h1111);
    st[3] = mk(1, 0, 3'd0, 16'h0000);
    st[4] = mk(1, 1, 3'd5, 16'h2222);
    st[5] = mk(1, 0, 3'd3, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step_a(st[i]);
      e = qa.pop_front();
      tests++;
      if ({a_dv, a_rdata, a_err, a_strb, a_regs} !== e) begin
        failed++;
        $display("FAIL write_read[%0d]: got dv=%b rd=%h err=%b strb=%b regs=%h, expected dv=%b rd=%h err=%b strb=%b regs=%h",
                 i, a_dv, a_rdata, a_err, a_strb, a_regs, e.dv, e.rdata, e.err, e.strb, e.regs);
      end
    end
  endtask

  task automatic test_read_only();
    stim_t  st [3];
    exp_a_t e;
    st[0] = mk(1, 1, 3'd1, 16'h00FF);
    st[1] = mk(1, 0, 3'd1, 16'h0000);
    st[2] = mk(0, 1, 3'd1, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      step_a(st[i]);
      e = qa.pop_front();
      tests++;
      if ({a_dv, a_rdata, a_err, a_strb, a_regs} !== e) begin
        failed++;
        $display("FAIL read_only[%0d]: got dv=%b rd=%h err=%b strb=%b regs=%h, expected dv=%b rd=%h err=%b strb=%b regs=%h",
                 i, a_dv, a_rdata, a_err, a_strb, a_regs, e.dv, e.rdata, e.err, e.strb, e.regs);
      end
    end
  endtask

  task automatic test_pulse();
    stim_t  st [7];
    exp_a_t e;
    st[0] = mk(1, 1, 3'd4, 16'h0001);
    st[1] = mk(0, 0, 3'd0, 16'h0000);
    st[2] = mk(0, 0, 3'd0, 16'h0000);
    st[3] = mk(1, 1, 3'd4, 16'h0001);
    st[4] = mk(1, 1, 3'd4, 16'h0002);
    st[5] = mk(0, 0, 3'd0, 16'h0000);
    st[6] = mk(0, 0, 3'd0, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step_a(st[i]);
      e = qa.pop_front();
      tests++;
      if ({a_dv, a_rdata, a_err, a_strb, a_regs} !== e) begin
        failed++;
        $display("FAIL pulse[%0d]: got dv=%b rd=%h err=%b strb=%b slice4=%h regs=%h, expected dv=%b rd=%h err=%b strb=%b slice4=%h",
                 i, a_dv, a_rdata, a_err, a_strb, a_regs[79:64], a_regs, e.dv, e.rdata, e.err, e.strb, e.regs[79:64]);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t  st [5];
    exp_a_t e;
    st[0] = mk(1, 1, 3'd3, 16'h7777);
    st[1] = mk(1, 0, 3'd3, 16'h0000);
    st[2] = mk(1, 0, 3'd7, 16'h0000);
    st[3] = mk(1, 1, 3'd6, 16'hFFFF);
    st[4] = mk(1, 0, 3'd6, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step_a(st[i]);
      e = qa.pop_front();
      tests++;
      if ({a_dv, a_rdata, a_err, a_strb, a_regs} !== e) begin
        failed++;
        $display("FAIL illegal[%0d]: got dv=%b rd=%h err=%b strb=%b regs=%h, expected dv=%b rd=%h err=%b strb=%b regs=%h",
                 i, a_dv, a_rdata, a_err, a_strb, a_regs, e.dv, e.rdata, e.err, e.strb, e.regs);
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] exp_d;
    b_cs = 1; b_wr = 1; b_addr = 3'd7; b_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({b_strb, b_regs, b_err, b_dv} !== {8'h80, 32'hDEADBEEF, 224'h0, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL wide_write: got strb=%b slice7=%h err=%b dv=%b, expected strb=10000000 slice7=deadbeef err=0 dv=0",
               b_strb, b_regs[255:224], b_err, b_dv);
    end
    for (int i = 0; i < 2; i++) begin
      b_wr = 0; b_addr = (i == 0) ? 3'd7 : 3'd0;
      qb.push_back((i == 0) ? 32'hDEADBEEF : 32'h0);
      @(posedge clk);
      @(negedge clk);
      b_cs = (i == 0);
      exp_d = qb.pop_front();
      tests++;
      if ({b_dv, b_err, b_strb} !== {1'b1, 1'b0, 8'h00} || b_rdata !== exp_d) begin
        failed++;
        $display("FAIL wide_read[%0d]: got dv=%b err=%b strb=%b data=%h, expected dv=1 err=0 strb=0 data=%h",
                 i, b_dv, b_err, b_strb, b_rdata, exp_d);
      end
    end
    b_cs = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_only();
    test_pulse();
    test_illegal();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
